// File: rtl/armleocpu_plic_scan_arbiter.sv
// Sequential per-context PLIC arbiter: one source ID compared per cycle,
// results committed at the end of each scan, plus claim handshake.
module armleocpu_plic_scan_arbiter #(
   parameter int INTERRUPT_SOURCE_COUNT       = 16,
   parameter int INTERRUPT_SOURCE_COUNT_CLOG2 = 4,
   parameter int PRIORITY_WIDTH               = 32
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [INTERRUPT_SOURCE_COUNT-1:0]            pending,
   input  logic [INTERRUPT_SOURCE_COUNT-1:0]            enable,
   input  logic [INTERRUPT_SOURCE_COUNT*PRIORITY_WIDTH-1:0] priorities,
   input  logic [PRIORITY_WIDTH-1:0]                    threshold,
   input  logic                                         scan_restart,
   input  logic                                         claim_req,
   output logic                                         claim_ack,
   output logic [INTERRUPT_SOURCE_COUNT_CLOG2:0]        claim_id,
   output logic                                         irq,
   output logic [INTERRUPT_SOURCE_COUNT_CLOG2:0]        max_id,
   output logic [PRIORITY_WIDTH-1:0]                    max_priority,
   output logic                                         scan_busy
);

   localparam int N   = INTERRUPT_SOURCE_COUNT;
   localparam int IDW = INTERRUPT_SOURCE_COUNT_CLOG2 + 1;
   localparam int PW  = PRIORITY_WIDTH;
   localparam logic [IDW-1:0] FIRST_IDX = IDW'(1);
   localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  idx_q, idx_d;
   logic [PW-1:0]   best_pri_q, best_pri_d;
   logic [IDW-1:0]  best_id_q, best_id_d;
   logic            irq_q, irq_d;
   logic [IDW-1:0]  max_id_q, max_id_d;
   logic [PW-1:0]   max_pri_q, max_pri_d;
   logic            claim_ack_q, claim_ack_d;
   logic [IDW-1:0]  claim_id_q, claim_id_d;

   logic            cur_pend;
   logic            cur_en;
   logic [PW-1:0]   cur_pri;
   logic [PW-1:0]   cur_calc;
   logic            cur_sel;
   logic [PW-1:0]   post_pri;
   logic [IDW-1:0]  post_id;

   // ID 0 is reserved, so its pending/enable/priority are never looked at
   logic unused_src0;
   assign unused_src0 = ^{pending[0], enable[0], priorities[PW-1:0]};

   // Select the source addressed by idx and apply the strict compare
   always_comb begin
      cur_pend = 1'b0;
      cur_en   = 1'b0;
      cur_pri  = '0;
      for (int i = 1; i < N; i++) begin
         if (idx_q == IDW'(i)) begin
            cur_pend = pending[i];
            cur_en   = enable[i];
            cur_pri  = priorities[i*PW +: PW];
         end
      end
      cur_calc = cur_pend ? cur_pri : '0;
      cur_sel  = cur_en && (cur_calc > best_pri_q);
      post_pri = cur_sel ? cur_calc : best_pri_q;
      post_id  = cur_sel ? idx_q : best_id_q;
   end

   // Scan sequencing, commit and claim handling
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      best_pri_d  = best_pri_q;
      best_id_d   = best_id_q;
      irq_d       = irq_q;
      max_id_d    = max_id_q;
      max_pri_d   = max_pri_q;
      claim_ack_d = 1'b0;
      claim_id_d  = '0;
      if (claim_req) begin
         claim_ack_d = 1'b1;
         claim_id_d  = irq_q ? max_id_q : '0;
         irq_d       = 1'b0;
         max_id_d    = '0;
         max_pri_d   = '0;
         state_d     = ST_SETTLE;
      end else if (scan_restart) begin
         state_d = ST_SETTLE;
      end else begin
         unique case (state_q)
            ST_SETTLE: begin
               best_pri_d = '0;
               best_id_d  = '0;
               idx_d      = FIRST_IDX;
               state_d    = ST_SCAN;
            end
            ST_SCAN: begin
               if (idx_q == LAST_IDX) begin
                  max_id_d   = post_id;
                  max_pri_d  = post_pri;
                  irq_d      = post_pri > threshold;
                  best_pri_d = '0;
                  best_id_d  = '0;
                  idx_d      = FIRST_IDX;
               end else begin
                  best_pri_d = post_pri;
                  best_id_d  = post_id;
                  idx_d      = idx_q + IDW'(1);
               end
            end
            default: state_d = ST_SETTLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SETTLE;
         idx_q       <= FIRST_IDX;
         best_pri_q  <= '0;
         best_id_q   <= '0;
         irq_q       <= 1'b0;
         max_id_q    <= '0;
         max_pri_q   <= '0;
         claim_ack_q <= 1'b0;
         claim_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         best_pri_q  <= best_pri_d;
         best_id_q   <= best_id_d;
         irq_q       <= irq_d;
         max_id_q    <= max_id_d;
         max_pri_q   <= max_pri_d;
         claim_ack_q <= claim_ack_d;
         claim_id_q  <= claim_id_d;
      end
   end

   assign claim_ack    = claim_ack_q;
   assign claim_id     = claim_id_q;
   assign irq          = irq_q;
   assign max_id       = max_id_q;
   assign max_priority = max_pri_q;
   assign scan_busy    = (state_q == ST_SCAN);

endmodule

// File: tb/tb_armleocpu_plic_scan_arbiter.sv
// Bench for the scan arbiter: directed scenarios plus randomized
// configurations checked against a whole-vector winner model.
module tb_armleocpu_plic_scan_arbiter;

   localparam int N    = 16;
   localparam int CL   = 4;
   localparam int PW   = 32;
   localparam int IDW  = CL + 1;
   localparam int WAIT = 2 * (N - 1) + 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    pending;
   logic [N-1:0]    enable;
   logic [N*PW-1:0] priorities;
   logic [PW-1:0]   threshold;
   logic            scan_restart;
   logic            claim_req;
   logic            claim_ack;
   logic [IDW-1:0]  claim_id;
   logic            irq;
   logic [IDW-1:0]  max_id;
   logic [PW-1:0]   max_priority;
   logic            scan_busy;

   logic [PW-1:0]   prio_arr [N];

   int checks   = 0;
   int failures = 0;

   armleocpu_plic_scan_arbiter #(
      .INTERRUPT_SOURCE_COUNT(N),
      .INTERRUPT_SOURCE_COUNT_CLOG2(CL),
      .PRIORITY_WIDTH(PW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pending(pending),
      .enable(enable),
      .priorities(priorities),
      .threshold(threshold),
      .scan_restart(scan_restart),
      .claim_req(claim_req),
      .claim_ack(claim_ack),
      .claim_id(claim_id),
      .irq(irq),
      .max_id(max_id),
      .max_priority(max_priority),
      .scan_busy(scan_busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) priorities[i*PW +: PW] = prio_arr[i];
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_inputs();
      pending      = '0;
      enable       = '0;
      threshold    = '0;
      scan_restart = 1'b0;
      claim_req    = 1'b0;
      for (int i = 0; i < N; i++) prio_arr[i] = '0;
   endtask

   // Highest effective priority among enabled sources 1..N-1, lowest ID on ties
   function automatic void ref_winner(output int id, output logic [PW-1:0] pri);
      logic [PW-1:0] eff;
      id  = 0;
      pri = '0;
      for (int i = 1; i < N; i++) begin
         eff = (pending[i] && enable[i]) ? prio_arr[i] : '0;
         if (eff != 0 && (eff > pri)) begin
            pri = eff;
            id  = i;
         end
      end
   endfunction

   task automatic setup_5_9(input logic [PW-1:0] thr);
      clear_inputs();
      pending[5]  = 1'b1;
      pending[9]  = 1'b1;
      enable[5]   = 1'b1;
      enable[9]   = 1'b1;
      prio_arr[5] = 3;
      prio_arr[9] = 7;
      threshold   = thr;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      checks++;
      if ({irq, max_id, max_priority, claim_ack, claim_id, scan_busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got irq=%0b id=%0d pri=%0d ack=%0b cid=%0d busy=%0b exp all 0",
                  irq, max_id, max_priority, claim_ack, claim_id, scan_busy);
      end
      step(16);
      checks++;
      if (irq !== 1'b0 || max_id !== 0 || max_priority !== 0 || scan_busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_idle got irq=%0b id=%0d pri=%0d busy=%0b exp 0/0/0/1",
                  irq, max_id, max_priority, scan_busy);
      end
   endtask

   task automatic test_basic();
      setup_5_9(2);
      step(30);
      checks++;
      if (max_id !== 9 || max_priority !== 7 || irq !== 1'b1) begin
         failures++;
         $display("FAIL basic got id=%0d pri=%0d irq=%0b exp 9/7/1", max_id, max_priority, irq);
      end
   endtask

   task automatic test_tie();
      clear_inputs();
      pending[4]   = 1'b1;
      pending[12]  = 1'b1;
      enable[4]    = 1'b1;
      enable[12]   = 1'b1;
      prio_arr[4]  = 6;
      prio_arr[12] = 6;
      step(WAIT);
      checks++;
      if (max_id !== 4 || max_priority !== 6 || irq !== 1'b1) begin
         failures++;
         $display("FAIL tie got id=%0d pri=%0d irq=%0b exp 4/6/1", max_id, max_priority, irq);
      end
   endtask

   task automatic test_threshold();
      setup_5_9(7);
      step(WAIT);
      checks++;
      if (irq !== 1'b0 || max_id !== 9) begin
         failures++;
         $display("FAIL thr_equal got irq=%0b id=%0d exp 0/9", irq, max_id);
      end
      threshold = 6;
      step(WAIT);
      checks++;
      if (irq !== 1'b1 || max_id !== 9) begin
         failures++;
         $display("FAIL thr_below got irq=%0b id=%0d exp 1/9", irq, max_id);
      end
   endtask

   task automatic test_claim();
      setup_5_9(2);
      step(WAIT);
      claim_req = 1'b1;
      step(1);
      claim_req = 1'b0;
      checks++;
      if (claim_ack !== 1'b1 || claim_id !== 9 || irq !== 1'b0 || max_id !== 0) begin
         failures++;
         $display("FAIL claim got ack=%0b cid=%0d irq=%0b id=%0d exp 1/9/0/0",
                  claim_ack, claim_id, irq, max_id);
      end
      pending[9] = 1'b0;
      step(1);
      checks++;
      if (claim_ack !== 1'b0) begin
         failures++;
         $display("FAIL claim_ack_pulse got %0b exp 0", claim_ack);
      end
      step(WAIT);
      checks++;
      if (max_id !== 5 || max_priority !== 3 || irq !== 1'b1) begin
         failures++;
         $display("FAIL reclaim_scan got id=%0d pri=%0d irq=%0b exp 5/3/1", max_id, max_priority, irq);
      end
      claim_req = 1'b1;
      step(1);
      checks++;
      if (claim_ack !== 1'b1 || claim_id !== 5) begin
         failures++;
         $display("FAIL b2b_first got ack=%0b cid=%0d exp 1/5", claim_ack, claim_id);
      end
      step(1);
      claim_req = 1'b0;
      checks++;
      if (claim_ack !== 1'b1 || claim_id !== 0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second got ack=%0b cid=%0d irq=%0b exp 1/0/0", claim_ack, claim_id, irq);
      end
   endtask

   task automatic test_commit_timing();
      setup_5_9(2);
      step(WAIT);
      scan_restart = 1'b1;
      enable[9]    = 1'b0;
      step(1);
      scan_restart = 1'b0;
      checks++;
      if (max_id !== 9 || irq !== 1'b1 || scan_busy !== 1'b0) begin
         failures++;
         $display("FAIL restart_hold got id=%0d irq=%0b busy=%0b exp 9/1/0", max_id, irq, scan_busy);
      end
      step(N - 1);
      checks++;
      if (max_id !== 9 || max_priority !== 7) begin
         failures++;
         $display("FAIL pre_commit_hold got id=%0d pri=%0d exp 9/7", max_id, max_priority);
      end
      step(1);
      checks++;
      if (max_id !== 5 || max_priority !== 3 || irq !== 1'b1) begin
         failures++;
         $display("FAIL commit_edge got id=%0d pri=%0d irq=%0b exp 5/3/1", max_id, max_priority, irq);
      end
   endtask

   task automatic test_claim_on_commit();
      enable[9]    = 1'b1;
      scan_restart = 1'b1;
      step(1);
      scan_restart = 1'b0;
      step(N - 1);
      claim_req = 1'b1;
      step(1);
      claim_req = 1'b0;
      checks++;
      if (claim_ack !== 1'b1 || claim_id !== 5 || max_id !== 0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL claim_on_commit got ack=%0b cid=%0d id=%0d irq=%0b exp 1/5/0/0",
                  claim_ack, claim_id, max_id, irq);
      end
      step(N - 1);
      checks++;
      if (max_id !== 0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL dropped_commit got id=%0d irq=%0b exp 0/0", max_id, irq);
      end
      step(1);
      checks++;
      if (max_id !== 9 || irq !== 1'b1) begin
         failures++;
         $display("FAIL after_claim_scan got id=%0d irq=%0b exp 9/1", max_id, irq);
      end
   endtask

   task automatic test_reset_mid_scan();
      setup_5_9(2);
      step(WAIT + 5);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      checks++;
      if ({irq, max_id, max_priority, claim_ack, claim_id, scan_busy} !== '0) begin
         failures++;
         $display("FAIL reset_mid_scan got irq=%0b id=%0d pri=%0d busy=%0b exp all 0",
                  irq, max_id, max_priority, scan_busy);
      end
      step(WAIT);
      checks++;
      if (max_id !== 9 || irq !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_scan got id=%0d irq=%0b exp 9/1", max_id, irq);
      end
   endtask

   task automatic test_random();
      int            exp_id;
      logic [PW-1:0] exp_pri;
      logic          exp_irq;
      for (int it = 0; it < 25; it++) begin
         pending   = N'($urandom);
         enable    = N'($urandom);
         threshold = PW'($urandom_range(0, 8));
         for (int i = 0; i < N; i++) begin
            prio_arr[i] = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : PW'($urandom_range(0, 7));
         end
         step(WAIT);
         ref_winner(exp_id, exp_pri);
         exp_irq = exp_pri > threshold;
         checks++;
         if (max_id !== IDW'(exp_id) || max_priority !== exp_pri || irq !== exp_irq) begin
            failures++;
            $display("FAIL rand_scan it=%0d got id=%0d pri=%0h irq=%0b exp %0d/%0h/%0b",
                     it, max_id, max_priority, irq, exp_id, exp_pri, exp_irq);
         end
         if ($urandom_range(0, 1) == 1) begin
            claim_req = 1'b1;
            step(1);
            claim_req = 1'b0;
            checks++;
            if (claim_ack !== 1'b1 || claim_id !== (exp_irq ? IDW'(exp_id) : '0) || irq !== 1'b0) begin
               failures++;
               $display("FAIL rand_claim it=%0d got ack=%0b cid=%0d irq=%0b exp 1/%0d/0",
                        it, claim_ack, claim_id, irq, exp_irq ? exp_id : 0);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_basic();
      test_tie();
      test_threshold();
      test_claim();
      test_commit_timing();
      test_claim_on_commit();
      test_reset_mid_scan();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
